// File: rtl/noc_adapter_tx_arbiter.sv
// Packet-granular round-robin arbiter that merges NUM_REQ AXI-Stream sources into one
// registered master port. The grant stays locked from the first beat to tlast.
module noc_adapter_tx_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int noc_dw  = 512,
    parameter int byte_dw = 8,
    parameter int user_dw = 32,
    localparam int IDW    = $clog2(NUM_REQ)
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [NUM_REQ-1:0]           s_tvalid,
    output logic [NUM_REQ-1:0]           s_tready,
    input  logic [NUM_REQ*noc_dw-1:0]    s_tdata,
    input  logic [NUM_REQ*byte_dw-1:0]   s_tdest,
    input  logic [NUM_REQ*user_dw-1:0]   s_tuser,
    input  logic [NUM_REQ-1:0]           s_tlast,
    input  logic                         m_tready,
    output logic                         m_tvalid,
    output logic [noc_dw-1:0]            m_tdata,
    output logic [byte_dw-1:0]           m_tdest,
    output logic [user_dw-1:0]           m_tuser,
    output logic                         m_tlast,
    output logic [byte_dw-1:0]           m_tid,
    output logic [noc_dw/byte_dw-1:0]    m_tstrb,
    output logic [noc_dw/byte_dw-1:0]    m_tkeep,
    output logic [IDW-1:0]               grant_idx,
    output logic                         busy
);

    typedef enum logic {
        IDLE,
        BUSY
    } state_t;

    state_t         state;
    logic [IDW-1:0] rr_ptr;
    logic [IDW-1:0] win_idx;
    logic [IDW-1:0] cand;
    logic           win_valid;
    logic           out_free;
    logic           accept;

    assign m_tstrb  = '1;
    assign m_tkeep  = '1;
    assign busy     = (state == BUSY);
    assign out_free = !m_tvalid || m_tready;
    assign accept   = (state == BUSY) && s_tvalid[grant_idx] && out_free;

    // Scan downward so the last hit is the requester closest after rr_ptr.
    always_comb begin
        win_valid = 1'b0;
        win_idx   = '0;
        cand      = '0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            cand = IDW'((int'(rr_ptr) + k) % NUM_REQ);
            if (s_tvalid[cand]) begin
                win_valid = 1'b1;
                win_idx   = cand;
            end
        end
    end

    always_comb begin
        s_tready = '0;
        if (state == BUSY) begin
            s_tready[grant_idx] = out_free;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            rr_ptr    <= IDW'(NUM_REQ - 1);
            grant_idx <= '0;
            m_tvalid  <= 1'b0;
            m_tdata   <= '0;
            m_tdest   <= '0;
            m_tuser   <= '0;
            m_tlast   <= 1'b0;
            m_tid     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (win_valid) begin
                        grant_idx <= win_idx;
                        state     <= BUSY;
                    end
                end
                BUSY: begin
                    if (accept && s_tlast[grant_idx]) begin
                        rr_ptr <= grant_idx;
                        state  <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase

            // A retiring beat and a newly accepted beat may swap in the same cycle.
            if (accept) begin
                m_tvalid <= 1'b1;
                m_tdata  <= s_tdata[grant_idx*noc_dw +: noc_dw];
                m_tdest  <= s_tdest[grant_idx*byte_dw +: byte_dw];
                m_tuser  <= s_tuser[grant_idx*user_dw +: user_dw];
                m_tlast  <= s_tlast[grant_idx];
                m_tid    <= {{(byte_dw-IDW){1'b0}}, grant_idx};
            end else if (m_tready) begin
                m_tvalid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_noc_adapter_tx_arbiter.sv
// Scoreboard bench for noc_adapter_tx_arbiter: per-requester packet queues drive the
// sources, and every beat leaving the master port is checked against the expected order.
module tb_noc_adapter_tx_arbiter;

    localparam int NUM_REQ = 4;
    localparam int NOC_DW  = 512;
    localparam int BYTE_DW = 8;
    localparam int USER_DW = 32;
    localparam int IDW     = $clog2(NUM_REQ);
    localparam int SW      = NOC_DW / BYTE_DW;

    logic                        clk = 1'b0;
    logic                        reset;
    logic [NUM_REQ-1:0]          s_tvalid;
    logic [NUM_REQ-1:0]          s_tready;
    logic [NUM_REQ*NOC_DW-1:0]   s_tdata;
    logic [NUM_REQ*BYTE_DW-1:0]  s_tdest;
    logic [NUM_REQ*USER_DW-1:0]  s_tuser;
    logic [NUM_REQ-1:0]          s_tlast;
    logic                        m_tready;
    logic                        m_tvalid;
    logic [NOC_DW-1:0]           m_tdata;
    logic [BYTE_DW-1:0]          m_tdest;
    logic [USER_DW-1:0]          m_tuser;
    logic                        m_tlast;
    logic [BYTE_DW-1:0]          m_tid;
    logic [SW-1:0]               m_tstrb;
    logic [SW-1:0]               m_tkeep;
    logic [IDW-1:0]              grant_idx;
    logic                        busy;

    noc_adapter_tx_arbiter #(
        .NUM_REQ(NUM_REQ), .noc_dw(NOC_DW), .byte_dw(BYTE_DW), .user_dw(USER_DW)
    ) dut (
        .clk(clk), .reset(reset),
        .s_tvalid(s_tvalid), .s_tready(s_tready), .s_tdata(s_tdata),
        .s_tdest(s_tdest), .s_tuser(s_tuser), .s_tlast(s_tlast),
        .m_tready(m_tready), .m_tvalid(m_tvalid), .m_tdata(m_tdata),
        .m_tdest(m_tdest), .m_tuser(m_tuser), .m_tlast(m_tlast), .m_tid(m_tid),
        .m_tstrb(m_tstrb), .m_tkeep(m_tkeep), .grant_idx(grant_idx), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [NOC_DW-1:0]  data;
        logic [BYTE_DW-1:0] dest;
        logic [USER_DW-1:0] user;
        logic               last;
        logic [BYTE_DW-1:0] tid;
    } beat_t;

    beat_t req_q [NUM_REQ][$];
    beat_t exp_q [$];
    bit    req_en [NUM_REQ];
    bit    hs [NUM_REQ];
    logic  m_ready_drv;
    int    cycle;
    int    checks;
    int    fails;
    int    fire_cycles [$];
    int    base;
    int    c0;
    int    n;
    int    t1_offs [6] = '{2, 3, 4, 6, 7, 8};

    task automatic checkOutput(input string tag, input logic [NOC_DW-1:0] actual,
                               input logic [NOC_DW-1:0] expected);
        checks++;
        if (actual !== expected) begin
            fails++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
        end
    endtask

    function automatic beat_t make_beat(int r, int p, int b, bit last);
        beat_t bt;
        bt.data = {16{8'(r), 8'(p), 16'(b)}};
        bt.dest = 8'(16 * r + p);
        bt.user = 32'hA500_0000 | 32'(p * 256 + b);
        bt.last = last;
        bt.tid  = 8'(r);
        return bt;
    endfunction

    task automatic applyStimulus(input int r, input int p, input int nbeats);
        for (int b = 0; b < nbeats; b++) req_q[r].push_back(make_beat(r, p, b, b == nbeats - 1));
    endtask

    task automatic expect_packet(input int r, input int p, input int nbeats);
        for (int b = 0; b < nbeats; b++) exp_q.push_back(make_beat(r, p, b, b == nbeats - 1));
    endtask

    // One cycle: retire handshakes from the last edge, drive new inputs, sample the master port.
    task automatic tick();
        beat_t e;
        @(negedge clk);
        cycle++;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (hs[i] && req_q[i].size() > 0) req_q[i].delete(0);
            hs[i] = 1'b0;
        end
        m_tready = m_ready_drv;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (req_en[i] && req_q[i].size() > 0) begin
                s_tvalid[i] = 1'b1;
                s_tdata[i*NOC_DW +: NOC_DW]   = req_q[i][0].data;
                s_tdest[i*BYTE_DW +: BYTE_DW] = req_q[i][0].dest;
                s_tuser[i*USER_DW +: USER_DW] = req_q[i][0].user;
                s_tlast[i] = req_q[i][0].last;
            end else begin
                s_tvalid[i] = 1'b0;
                s_tlast[i]  = 1'b0;
            end
        end
        #1;
        for (int i = 0; i < NUM_REQ; i++) hs[i] = s_tvalid[i] && s_tready[i];
        if (m_tvalid && m_tready) begin
            fire_cycles.push_back(cycle);
            if (exp_q.size() == 0) begin
                checkOutput("pending_expected", NOC_DW'(exp_q.size()), 1);
            end else begin
                e = exp_q.pop_front();
                checkOutput("m_tid", m_tid, e.tid);
                checkOutput("m_tdata", m_tdata, e.data);
                checkOutput("m_tdest", m_tdest, e.dest);
                checkOutput("m_tuser", m_tuser, e.user);
                checkOutput("m_tlast", m_tlast, e.last);
            end
        end
    endtask

    task automatic drain(input int bound);
        int k;
        k = 0;
        while (exp_q.size() > 0 && k < bound) begin
            tick();
            k++;
        end
        if (exp_q.size() > 0) checkOutput("drain_timeout", NOC_DW'(exp_q.size()), 0);
        tick();
        tick();
    endtask

    task automatic wait_fires(input int target, input int bound);
        int k;
        k = 0;
        while (fire_cycles.size() < target && k < bound) begin
            tick();
            k++;
        end
        if (fire_cycles.size() < target) checkOutput("fire_timeout", NOC_DW'(fire_cycles.size()), NOC_DW'(target));
    endtask

    task automatic clear_stimulus();
        for (int i = 0; i < NUM_REQ; i++) begin
            req_q[i].delete();
            hs[i]     = 1'b0;
            req_en[i] = 1'b1;
        end
        exp_q.delete();
        s_tvalid = '0;
        s_tlast  = '0;
    endtask

    task automatic apply_reset();
        reset = 1'b0;
        clear_stimulus();
        tick();
        tick();
        reset = 1'b1;
        tick();
    endtask

    initial begin
        checks = 0;
        fails = 0;
        cycle = 0;
        m_ready_drv = 1'b1;
        m_tready = 1'b1;
        s_tdata = '0;
        s_tdest = '0;
        s_tuser = '0;
        reset = 1'b0;
        clear_stimulus();
        tick();
        tick();

        checkOutput("rst_m_tvalid", m_tvalid, 0);
        checkOutput("rst_m_tdata", m_tdata, 0);
        checkOutput("rst_m_tid", m_tid, 0);
        checkOutput("rst_m_tlast", m_tlast, 0);
        checkOutput("rst_s_tready", s_tready, 0);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_grant_idx", grant_idx, 0);
        checkOutput("m_tkeep", m_tkeep, {SW{1'b1}});
        checkOutput("m_tstrb", m_tstrb, {SW{1'b1}});
        reset = 1'b1;
        tick();

        $display("[TB] two 3-beat packets from requesters 0 and 2");
        applyStimulus(0, 1, 3);
        applyStimulus(2, 1, 3);
        expect_packet(0, 1, 3);
        expect_packet(2, 1, 3);
        base = fire_cycles.size();
        tick();
        c0 = cycle;
        drain(40);
        checkOutput("t1_fire_count", NOC_DW'(fire_cycles.size() - base), 6);
        if (fire_cycles.size() - base >= 6)
            for (int k = 0; k < 6; k++)
                checkOutput($sformatf("t1_fire_offset%0d", k), NOC_DW'(fire_cycles[base+k] - c0), NOC_DW'(t1_offs[k]));

        $display("[TB] four requesters with single-beat packets");
        apply_reset();
        for (int pk = 0; pk < 2; pk++)
            for (int r = 0; r < NUM_REQ; r++) begin
                applyStimulus(r, 10 + pk, 1);
                expect_packet(r, 10 + pk, 1);
            end
        base = fire_cycles.size();
        drain(60);
        checkOutput("t2_fire_count", NOC_DW'(fire_cycles.size() - base), 8);
        if (fire_cycles.size() - base >= 8)
            for (int k = 1; k < 8; k++)
                checkOutput($sformatf("t2_spacing%0d", k), NOC_DW'(fire_cycles[base+k] - fire_cycles[base+k-1]), 2);

        $display("[TB] master back-pressure mid-packet");
        applyStimulus(1, 20, 6);
        expect_packet(1, 20, 6);
        base = fire_cycles.size();
        wait_fires(base + 2, 20);
        m_ready_drv = 1'b0;
        for (int k = 0; k < 5; k++) begin
            tick();
            checkOutput("t3_hold_valid", m_tvalid, 1);
            if (exp_q.size() > 0) checkOutput("t3_hold_data", m_tdata, exp_q[0].data);
            checkOutput("t3_s_tready", s_tready, 0);
        end
        m_ready_drv = 1'b1;
        drain(40);
        checkOutput("t3_fire_count", NOC_DW'(fire_cycles.size() - base), 6);

        $display("[TB] granted requester pauses while another waits");
        apply_reset();
        applyStimulus(1, 30, 4);
        applyStimulus(3, 31, 2);
        expect_packet(1, 30, 4);
        expect_packet(3, 31, 2);
        base = fire_cycles.size();
        wait_fires(base + 2, 20);
        req_en[1] = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tick();
            checkOutput("t4_grant_idx", grant_idx, 1);
            checkOutput("t4_busy", busy, 1);
            checkOutput("t4_s_tready3", s_tready[3], 0);
        end
        req_en[1] = 1'b1;
        drain(40);
        checkOutput("t4_fire_count", NOC_DW'(fire_cycles.size() - base), 6);

        $display("[TB] reset during a 4-beat packet");
        applyStimulus(0, 40, 1);
        applyStimulus(2, 41, 4);
        expect_packet(0, 40, 1);
        expect_packet(2, 41, 4);
        base = fire_cycles.size();
        wait_fires(base + 2, 20);
        @(posedge clk);
        #2;
        checkOutput("t5_pre_reset_valid", m_tvalid, 1);
        if (exp_q.size() > 0) checkOutput("t5_pre_reset_data", m_tdata, exp_q[0].data);
        reset = 1'b0;
        #1;
        checkOutput("t5_async_m_tvalid", m_tvalid, 0);
        checkOutput("t5_async_busy", busy, 0);
        checkOutput("t5_async_grant_idx", grant_idx, 0);
        checkOutput("t5_async_s_tready", s_tready, 0);
        clear_stimulus();
        tick();
        reset = 1'b1;
        tick();
        applyStimulus(0, 42, 1);
        applyStimulus(3, 43, 1);
        expect_packet(0, 42, 1);
        expect_packet(3, 43, 1);
        drain(30);

        $display("[TB] 8-beat packet at full throughput");
        applyStimulus(2, 50, 8);
        expect_packet(2, 50, 8);
        base = fire_cycles.size();
        drain(40);
        n = fire_cycles.size() - base;
        checkOutput("t6_fire_count", NOC_DW'(n), 8);
        if (n >= 8)
            for (int k = 1; k < 8; k++)
                checkOutput($sformatf("t6_spacing%0d", k), NOC_DW'(fire_cycles[base+k] - fire_cycles[base+k-1]), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
